iob_fifo_sync_assim: RTL and testbench



---
 rtl/iob_fifo_sync_assim_pkg.sv | 53 +++++
 rtl/iob_ram_2p_assim_sync.sv | 80 ++++++++
 rtl/iob_fifo_sync_assim.sv | 107 ++++++++++
 tb/tb_iob_fifo_sync_assim.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_sync_assim_pkg.sv
// Shared constants, helper functions and parameter-legality checks for the
// asymmetric synchronous FIFO and its RAM.
package iob_fifo_sync_assim_pkg;

  localparam int DEF_W_DATA_W = 32;
  localparam int DEF_R_DATA_W = 8;
  localparam int DEF_ADDR_W   = 6;

  typedef enum logic [1:0] {
    MODE_EQUAL,
    MODE_PACK,    // narrow write, wide read
    MODE_UNPACK   // wide write, narrow read
  } ram_mode_e;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int f_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int f_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit f_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic ram_mode_e f_mode(input int w_w, input int r_w);
    if (w_w < r_w) return MODE_PACK;
    if (w_w > r_w) return MODE_UNPACK;
    return MODE_EQUAL;
  endfunction

  function automatic bit f_params_ok(input int w_w, input int r_w, input int addr_w);
    int min_w;
    int max_w;
    min_w = f_min(w_w, r_w);
    max_w = f_max(w_w, r_w);
    if (min_w <= 0) return 1'b0;
    if ((max_w % min_w) != 0) return 1'b0;
    if (!f_is_pow2(max_w / min_w)) return 1'b0;
    return addr_w >= f_log2(max_w / min_w) + 1;
  endfunction

endpackage

// File: rtl/iob_ram_2p_assim_sync.sv
// Single-clock two-port RAM with asymmetric port widths; MAX_W-wide rows,
// the narrow port picks its lane from the low address bits. Registered read.
module iob_ram_2p_assim_sync
  import iob_fifo_sync_assim_pkg::*;
#(
  parameter int W_DATA_W = DEF_W_DATA_W,
  parameter int R_DATA_W = DEF_R_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int MIN_W      = f_min(W_DATA_W, R_DATA_W);
  localparam int MAX_W      = f_max(W_DATA_W, R_DATA_W);
  localparam int N_LANES    = MAX_W / MIN_W;
  localparam int RATIO_LOG2 = f_log2(N_LANES);
  localparam int ROW_W      = ADDR_W - RATIO_LOG2;
  localparam int DEPTH      = 1 << ROW_W;
  localparam ram_mode_e MODE = f_mode(W_DATA_W, R_DATA_W);

  // NOTE: the storage array has no reset; only the output register is cleared.
  logic [N_LANES-1:0][MIN_W-1:0] mem_q [DEPTH];
  logic [ROW_W-1:0]    w_row;
  logic [ROW_W-1:0]    r_row;
  logic [R_DATA_W-1:0] rd_word;
  logic [R_DATA_W-1:0] r_data_d;
  logic [R_DATA_W-1:0] r_data_q;

  assign w_row = w_addr[ADDR_W-1:RATIO_LOG2];
  assign r_row = r_addr[ADDR_W-1:RATIO_LOG2];

  if (MODE == MODE_PACK) begin : g_pack
    logic [RATIO_LOG2-1:0] w_lane;
    logic                  unused_r_lane;
    assign w_lane        = w_addr[RATIO_LOG2-1:0];
    assign unused_r_lane = ^r_addr[RATIO_LOG2-1:0];

    always_ff @(posedge clk) begin
      if (w_en) mem_q[w_row][w_lane] <= w_data;
    end
    assign rd_word = mem_q[r_row];
  end else if (MODE == MODE_UNPACK) begin : g_unpack
    logic [RATIO_LOG2-1:0] r_lane;
    logic                  unused_w_lane;
    assign r_lane        = r_addr[RATIO_LOG2-1:0];
    assign unused_w_lane = ^w_addr[RATIO_LOG2-1:0];

    always_ff @(posedge clk) begin
      if (w_en) mem_q[w_row] <= w_data;
    end
    assign rd_word = mem_q[r_row][r_lane];
  end else begin : g_equal
    always_ff @(posedge clk) begin
      if (w_en) mem_q[w_row] <= w_data;
    end
    assign rd_word = mem_q[r_row];
  end

  // NOTE: always_comb gives every output a default first, so no latch is inferred.
  always_comb begin
    r_data_d = r_data_q;
    if (r_en) r_data_d = rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) r_data_q <= '0;
    else     r_data_q <= r_data_d;
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/iob_fifo_sync_assim.sv
// Single-clock FIFO with asymmetric write/read widths (little-endian pack or
// unpack), exact fill level, almost-full/empty flags and error pulses.
module iob_fifo_sync_assim
  import iob_fifo_sync_assim_pkg::*;
#(
  parameter int W_DATA_W  = DEF_W_DATA_W,
  parameter int R_DATA_W  = DEF_R_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = (1 << ADDR_W) - 8,
  parameter int AEMPTY_TH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  output logic                w_afull,
  output logic                w_ovf,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic                r_aempty,
  output logic                r_unf,
  output logic [ADDR_W:0]     level
);

  localparam int MIN_W   = f_min(W_DATA_W, R_DATA_W);
  localparam int W_RATIO = W_DATA_W / MIN_W;
  localparam int R_RATIO = R_DATA_W / MIN_W;
  localparam int LVL_W   = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] W_STEP     = ADDR_W'(W_RATIO);
  localparam logic [ADDR_W-1:0] R_STEP     = ADDR_W'(R_RATIO);
  localparam logic [ADDR_W:0]   W_LVL      = LVL_W'(W_RATIO);
  localparam logic [ADDR_W:0]   R_LVL      = LVL_W'(R_RATIO);
  localparam logic [ADDR_W:0]   FULL_LVL   = LVL_W'((1 << ADDR_W) - W_RATIO);
  localparam logic [ADDR_W:0]   AFULL_LVL  = LVL_W'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_LVL = LVL_W'(AEMPTY_TH);

  if (!f_params_ok(W_DATA_W, R_DATA_W, ADDR_W)) begin : g_param_check
    $error("iob_fifo_sync_assim: width ratio must be a power of two and ADDR_W > log2(ratio)");
  end

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              w_ovf_q, w_ovf_d;
  logic              r_unf_q, r_unf_d;
  logic              w_acc;
  logic              r_acc;

  // Flags come from the registered level only, so a same-cycle read never frees a write.
  assign w_full   = level_q > FULL_LVL;
  assign r_empty  = level_q < R_LVL;
  assign w_afull  = level_q >= AFULL_LVL;
  assign r_aempty = level_q <= AEMPTY_LVL;

  assign w_acc = w_en & ~w_full;
  assign r_acc = r_en & ~r_empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (w_acc) wptr_d = wptr_q + W_STEP;
    if (r_acc) rptr_d = rptr_q + R_STEP;
    level_d = level_q + (w_acc ? W_LVL : '0) - (r_acc ? R_LVL : '0);
    w_ovf_d = w_en & w_full;
    r_unf_d = r_en & r_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      w_ovf_q <= 1'b0;
      r_unf_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      w_ovf_q <= w_ovf_d;
      r_unf_q <= r_unf_d;
    end
  end

  // The RAM's registered read port doubles as the FIFO read-data register.
  iob_ram_2p_assim_sync #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_acc),
    .w_addr (wptr_q),
    .w_data (w_data),
    .r_en   (r_acc),
    .r_addr (rptr_q),
    .r_data (r_data)
  );

  assign level = level_q;
  assign w_ovf = w_ovf_q;
  assign r_unf = r_unf_q;

endmodule

// File: tb/tb_iob_fifo_sync_assim.sv
// Directed and scoreboard checks for iob_fifo_sync_assim in pack (8->32) and
// unpack (32->8) configurations.
module tb_iob_fifo_sync_assim;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Pack instance: W=8, R=32, ADDR_W=4, AFULL_TH=12, AEMPTY_TH=4
  logic        p_w_en, p_r_en;
  logic [7:0]  p_w_data;
  logic        p_w_full, p_w_afull, p_w_ovf, p_r_empty, p_r_aempty, p_r_unf;
  logic [31:0] p_r_data;
  logic [4:0]  p_level;

  // Unpack instance: W=32, R=8, ADDR_W=4
  logic        u_w_en, u_r_en;
  logic [31:0] u_w_data;
  logic        u_w_full, u_w_afull, u_w_ovf, u_r_empty, u_r_aempty, u_r_unf;
  logic [7:0]  u_r_data;
  logic [4:0]  u_level;

  int total = 0;
  int bad   = 0;

  iob_fifo_sync_assim #(
    .W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4)
  ) dut_pack (
    .clk(clk), .rst(rst),
    .w_en(p_w_en), .w_data(p_w_data), .w_full(p_w_full), .w_afull(p_w_afull), .w_ovf(p_w_ovf),
    .r_en(p_r_en), .r_data(p_r_data), .r_empty(p_r_empty), .r_aempty(p_r_aempty), .r_unf(p_r_unf),
    .level(p_level)
  );

  iob_fifo_sync_assim #(
    .W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .AFULL_TH(8), .AEMPTY_TH(8)
  ) dut_unpack (
    .clk(clk), .rst(rst),
    .w_en(u_w_en), .w_data(u_w_data), .w_full(u_w_full), .w_afull(u_w_afull), .w_ovf(u_w_ovf),
    .r_en(u_r_en), .r_data(u_r_data), .r_empty(u_r_empty), .r_aempty(u_r_aempty), .r_unf(u_r_unf),
    .level(u_level)
  );

  // Advance one edge and settle 1 time unit past it before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_w_en = 1'b0; p_r_en = 1'b0;
    u_w_en = 1'b0; u_r_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p_w_en = 1'b1; p_r_en = 1'b1; p_w_data = 8'h5A;
    u_w_en = 1'b1; u_r_en = 1'b1; u_w_data = 32'hDEADBEEF;
    tick();
    tick();
    total++; if (p_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", p_level); end
    total++; if (p_r_empty !== 1'b1) begin bad++; $display("FAIL reset_r_empty got=%b exp=1", p_r_empty); end
    total++; if (p_w_full !== 1'b0) begin bad++; $display("FAIL reset_w_full got=%b exp=0", p_w_full); end
    total++; if (p_r_data !== 32'h0) begin bad++; $display("FAIL reset_r_data got=%h exp=0", p_r_data); end
    total++; if ({p_w_ovf, p_r_unf} !== 2'b00) begin bad++; $display("FAIL reset_err_pulses got=%b exp=00", {p_w_ovf, p_r_unf}); end
    total++; if ({p_r_aempty, p_w_afull} !== 2'b10) begin bad++; $display("FAIL reset_thresh got=%b exp=10", {p_r_aempty, p_w_afull}); end
    total++; if ({u_level, u_r_empty} !== {5'd0, 1'b1}) begin bad++; $display("FAIL reset_unpack got=%0d/%b exp=0/1", u_level, u_r_empty); end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_pack();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      p_w_en = 1'b1; p_w_data = bytes[i];
      tick();
      total++;
      if (p_r_empty !== (i < 3)) begin bad++; $display("FAIL pack_empty_w%0d got=%b exp=%b", i, p_r_empty, i < 3); end
    end
    p_w_en = 1'b0;
    total++; if (p_level !== 5'd4) begin bad++; $display("FAIL pack_level4 got=%0d exp=4", p_level); end
    p_r_en = 1'b1;
    tick();
    p_r_en = 1'b0;
    total++; if (p_r_data !== 32'h44332211) begin bad++; $display("FAIL pack_rdata got=%h exp=44332211", p_r_data); end
    total++; if (p_level !== 5'd0) begin bad++; $display("FAIL pack_level0 got=%0d exp=0", p_level); end
    tick();
    total++; if (p_r_data !== 32'h44332211) begin bad++; $display("FAIL pack_rdata_hold got=%h exp=44332211", p_r_data); end
  endtask

  task automatic test_unpack();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
    u_w_en = 1'b1; u_w_data = 32'hA1B2C3D4;
    tick();
    u_w_en = 1'b0;
    total++; if ({u_level, u_r_empty} !== {5'd4, 1'b0}) begin bad++; $display("FAIL unpack_after_write got=%0d/%b exp=4/0", u_level, u_r_empty); end
    u_r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (u_r_data !== exp_b[i]) begin bad++; $display("FAIL unpack_byte%0d got=%h exp=%h", i, u_r_data, exp_b[i]); end
    end
    u_r_en = 1'b0;
    total++; if ({u_level, u_r_empty} !== {5'd0, 1'b1}) begin bad++; $display("FAIL unpack_drained got=%0d/%b exp=0/1", u_level, u_r_empty); end
  endtask

  task automatic test_full_ovf();
    logic [31:0] exp_w;
    for (int i = 0; i < 16; i++) begin
      p_w_en = 1'b1; p_w_data = 8'(8'hA0 + i);
      tick();
      total++;
      if (p_w_afull !== (i + 1 >= 12)) begin bad++; $display("FAIL afull_lvl%0d got=%b exp=%b", i + 1, p_w_afull, i + 1 >= 12); end
      total++;
      if (p_r_aempty !== (i + 1 <= 4)) begin bad++; $display("FAIL aempty_lvl%0d got=%b exp=%b", i + 1, p_r_aempty, i + 1 <= 4); end
    end
    total++; if ({p_level, p_w_full} !== {5'd16, 1'b1}) begin bad++; $display("FAIL full_level got=%0d/%b exp=16/1", p_level, p_w_full); end
    p_w_data = 8'hFF;
    tick();
    p_w_en = 1'b0;
    total++; if (p_w_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", p_w_ovf); end
    total++; if (p_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", p_level); end
    tick();
    total++; if (p_w_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", p_w_ovf); end
    p_r_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_w = {8'(8'hA3 + 4 * k), 8'(8'hA2 + 4 * k), 8'(8'hA1 + 4 * k), 8'(8'hA0 + 4 * k)};
      total++;
      if (p_r_data !== exp_w) begin bad++; $display("FAIL full_read%0d got=%h exp=%h", k, p_r_data, exp_w); end
    end
    p_r_en = 1'b0;
    total++; if (p_level !== 5'd0) begin bad++; $display("FAIL full_drained got=%0d exp=0", p_level); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  q [$];
    logic [31:0] exp_w;
    logic        we, re, m_full, m_empty;
    logic [7:0]  d;
    for (int c = 0; c < 200; c++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      m_full  = (q.size() == 16);
      m_empty = (q.size() < 4);
      p_w_en = we; p_r_en = re; p_w_data = d;
      tick();
      if (re && !m_empty) begin
        exp_w = {q[3], q[2], q[1], q[0]};
        repeat (4) void'(q.pop_front());
        total++;
        if (p_r_data !== exp_w) begin bad++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, p_r_data, exp_w); end
      end
      if (we && !m_full) q.push_back(d);
      total++;
      if (p_level !== 5'(q.size())) begin bad++; $display("FAIL rand_level c=%0d got=%0d exp=%0d", c, p_level, q.size()); end
      total++;
      if (p_r_unf !== (re && m_empty)) begin bad++; $display("FAIL rand_unf c=%0d got=%b exp=%b", c, p_r_unf, re && m_empty); end
      total++;
      if (p_w_ovf !== (we && m_full)) begin bad++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, p_w_ovf, we && m_full); end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p_w_en = 1'b1; p_w_data = 8'(8'h70 + i);
      tick();
    end
    p_w_en = 1'b0;
    total++; if ({p_level, p_r_aempty} !== {5'd8, 1'b0}) begin bad++; $display("FAIL mid_pre_level got=%0d/%b exp=8/0", p_level, p_r_aempty); end
    rst = 1'b1; p_w_en = 1'b1; p_r_en = 1'b1;
    tick();
    rst = 1'b0; p_w_en = 1'b0; p_r_en = 1'b0;
    total++; if ({p_level, p_r_empty, p_r_aempty} !== {5'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/1/1", p_level, p_r_empty, p_r_aempty); end
    for (int i = 0; i < 4; i++) begin
      p_w_en = 1'b1; p_w_data = 8'(8'hC0 + i);
      tick();
    end
    p_w_en = 1'b0; p_r_en = 1'b1;
    tick();
    p_r_en = 1'b0;
    total++; if (p_r_data !== 32'hC3C2C1C0) begin bad++; $display("FAIL mid_fresh_data got=%h exp=c3c2c1c0", p_r_data); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    p_w_data = '0;
    u_w_data = '0;
    test_reset();
    test_pack();
    test_unpack();
    test_full_ovf();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
